// File: rtl/rsa_decrypt.sv
// RSA decryption core: message = cipher^d mod n, computed by constant-time LSB-first
// square-and-multiply over two bit-serial interleaved modular multipliers.
module rsa_decrypt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cipher,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] message,
  output logic             error,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One interleaved step: acc*2 (+a when the base bit is set), reduced mod m.
  // acc and a stay below m, so every intermediate fits in WIDTH+2 bits.
  function automatic logic [WIDTH:0] mod_step(input logic [WIDTH:0]   acc,
                                              input logic [WIDTH-1:0] a,
                                              input logic             bit_set,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] t;
    t = {acc, 1'b0};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    else                 t = t;
    if (bit_set) t = t + {2'b00, a};
    else         t = t;
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    else                 t = t;
    return t[WIDTH:0];
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH:0]   acc1_q, acc1_d;
  logic [WIDTH:0]   acc2_q, acc2_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] message_q, message_d;
  logic             error_q, error_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             base_bit_s;
  logic [WIDTH:0]   p1_s;
  logic [WIDTH:0]   p2_s;
  logic [WIDTH-1:0] new_result_s;

  assign base_bit_s   = base_q[LAST_C - step_q];
  assign p1_s         = mod_step(acc1_q, result_q, base_bit_s, n_q);
  assign p2_s         = mod_step(acc2_q, base_q, base_bit_s, n_q);
  assign new_result_s = exp_q[0] ? p1_s[WIDTH-1:0] : result_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    base_d    = base_q;
    exp_d     = exp_q;
    n_d       = n_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    bit_d     = bit_q;
    step_d    = step_q;
    message_d = message_q;
    error_d   = error_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d    = n;
          base_d = cipher;
          exp_d  = d;
          if ((n < WIDTH'(2)) || (cipher >= n)) begin
            state_d   = DONE;
            error_d   = 1'b1;
            message_d = {WIDTH{1'b0}};
          end else begin
            state_d  = COMPUTE;
            result_d = {{(WIDTH-1){1'b0}}, 1'b1};
            acc1_d   = {(WIDTH+1){1'b0}};
            acc2_d   = {(WIDTH+1){1'b0}};
            bit_d    = {CW{1'b0}};
            step_d   = {CW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        if (step_q == LAST_C) begin
          // End of a period: P1 is always formed, only its use depends on exp[0].
          acc1_d   = {(WIDTH+1){1'b0}};
          acc2_d   = {(WIDTH+1){1'b0}};
          step_d   = {CW{1'b0}};
          result_d = new_result_s;
          base_d   = p2_s[WIDTH-1:0];
          exp_d    = exp_q >> 1;
          bit_d    = bit_q + ONE_C;
          if (bit_q == LAST_C) begin
            state_d   = DONE;
            message_d = new_result_s;
            error_d   = 1'b0;
          end else begin
            state_d = COMPUTE;
          end
        end else begin
          acc1_d = p1_s;
          acc2_d = p2_s;
          step_d = step_q + ONE_C;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      result_q    <= {WIDTH{1'b0}};
      base_q      <= {WIDTH{1'b0}};
      exp_q       <= {WIDTH{1'b0}};
      n_q         <= {WIDTH{1'b0}};
      acc1_q      <= {(WIDTH+1){1'b0}};
      acc2_q      <= {(WIDTH+1){1'b0}};
      bit_q       <= {CW{1'b0}};
      step_q      <= {CW{1'b0}};
      message_q   <= {WIDTH{1'b0}};
      error_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      n_q         <= n_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      bit_q       <= bit_d;
      step_q      <= step_d;
      message_q   <= message_d;
      error_q     <= error_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign message   = message_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Self-checking bench for rsa_decrypt: directed vector table, hand-written corner
// sequences and a randomized sweep checked against a plain-arithmetic modexp model.
module tb_rsa_decrypt;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] cipher = 16'd0;
  logic [15:0] d = 16'd0;
  logic [15:0] n = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] message;
  logic        error;
  logic        busy;

  int total = 0;
  int bad = 0;

  rsa_decrypt #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .cipher(cipher), .d(d), .n(n),
    .out_valid(out_valid), .out_ready(out_ready),
    .message(message), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c;
    logic [15:0] dd;
    logic [15:0] nn;
    logic [15:0] msg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  // Reference: plain right-to-left modular exponentiation with 64-bit arithmetic.
  function automatic logic [15:0] modexp(input longint unsigned c, input longint unsigned e,
                                         input longint unsigned m);
    longint unsigned r, b;
    r = 1;
    b = c % m;
    for (int i = 0; i < 16; i++) begin
      if (((e >> i) & 1) == 1) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[15:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  // Drive one job, measure latency from the accept edge, optionally poke in_valid
  // while busy and hold off out_ready, then complete the result handshake.
  task automatic run_job(input string tag, input logic [15:0] c, input logic [15:0] dd,
                         input logic [15:0] nn, input logic [15:0] emsg, input logic eerr,
                         input int elat, input bit poke, input int hold);
    int lat;
    logic [15:0] m0;
    logic        e0;
    @(negedge clk);
    cipher = c; d = dd; n = nn; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".in_ready_after_accept"}, in_ready, 0);
    check({tag, ".busy_after_accept"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        cipher = 16'($urandom); d = 16'($urandom); n = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, lat, elat);
    check({tag, ".message"}, message, emsg);
    check({tag, ".error"}, error, eerr);
    m0 = message;
    e0 = error;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        cipher = 16'd5; d = 16'd3; n = 16'd11;
      end
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_message"}, message, m0);
      check({tag, ".hold_error"}, error, e0);
      check({tag, ".hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_after_handshake"}, out_valid, 0);
    check({tag, ".ready_after_handshake"}, in_ready, 1);
    check({tag, ".busy_after_handshake"}, busy, 0);
    check({tag, ".message_kept"}, message, m0);
  endtask

  initial begin
    logic [15:0] m, c, nn, dd;

    tbl[0] = '{16'd2790,  16'd2753, 16'd3233,  16'd65, 1'b0, 256};
    tbl[1] = '{16'd65534, 16'd2,    16'd65535, 16'd1,  1'b0, 256};
    tbl[2] = '{16'd7,     16'd0,    16'd65535, 16'd1,  1'b0, 256};
    tbl[3] = '{16'd0,     16'd1,    16'd1,     16'd0,  1'b1, 0};
    tbl[4] = '{16'd2790,  16'd2753, 16'd3233,  16'd65, 1'b0, 256};
    tbl[5] = '{16'd3233,  16'd2753, 16'd3233,  16'd0,  1'b1, 0};
    tbl[6] = '{16'd3,     16'd5,    16'd7,     16'd5,  1'b0, 256};
    tbl[7] = '{16'd0,     16'd9,    16'd3233,  16'd0,  1'b0, 256};

    #23;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.message", message, 0);
    check("reset.error", error, 0);
    check("reset.busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_job($sformatf("vec%0d", i), tbl[i].c, tbl[i].dd, tbl[i].nn,
              tbl[i].msg, tbl[i].err, tbl[i].lat, 1'b0, 0);

    // Backpressure with in_valid pokes during COMPUTE and DONE.
    run_job("backpressure", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 256, 1'b1, 20);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_job_started.busy", busy, 0);
    end

    // Round trip through the encryption exponent.
    c = modexp(64'd1234, 64'd17, 64'd3233);
    run_job("roundtrip1234", c, 16'd2753, 16'd3233, 16'd1234, 1'b0, 256, 1'b0, 0);
    for (int i = 0; i < 50; i++) begin
      m = 16'($urandom_range(0, 3232));
      c = modexp(64'(m), 64'd17, 64'd3233);
      run_job($sformatf("rt%0d_m%0d", i, m), c, 16'd2753, 16'd3233, m, 1'b0, 256, 1'b0, 0);
    end

    // Random moduli/exponents against the model.
    for (int i = 0; i < 12; i++) begin
      nn = 16'($urandom_range(2, 65535));
      c  = 16'($urandom_range(0, 32'(nn) - 1));
      dd = 16'($urandom);
      run_job($sformatf("rnd%0d", i), c, dd, nn, modexp(64'(c), 64'(dd), 64'(nn)),
              1'b0, 256, 1'b0, 0);
    end

    // Reset dropped mid-COMPUTE aborts the job with no result.
    @(negedge clk);
    cipher = 16'd2790; d = 16'd2753; n = 16'd3233; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset.in_ready", in_ready, 1);
    check("midreset.out_valid", out_valid, 0);
    check("midreset.message", message, 0);
    check("midreset.error", error, 0);
    check("midreset.busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
      if (out_valid) check("midreset.spurious_result", out_valid, 0);
    end
    run_job("after_reset", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 256, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_decrypt.md
Name: rsa_decrypt

Overview:
Receive side of the RSA path. Recovers plaintext message = cipher^d mod n using the private exponent d. It pairs with the team's RSA encryption core, which produces the ciphertext. Exponentiation is constant-time LSB-first square-and-multiply built on two bit-serial interleaved modular multipliers, so no wide multiplier or divider is needed. Operands enter and results leave over valid/ready handshakes.

Parameters:
WIDTH, 16, width of cipher, d, n and message.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  cipher/d/n valid
in_ready  output  1  block can accept an operand set (high only in IDLE)
cipher  input  WIDTH  ciphertext
d  input  WIDTH  private exponent
n  input  WIDTH  modulus
out_valid  output  1  message/error valid
out_ready  input  1  downstream accepts result
message  output  WIDTH  recovered plaintext
error  output  1  operands rejected (n < 2 or cipher >= n)
busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready=1; out_valid=0; message=0; error=0; busy=0; all internal registers 0.
- Reset asserted mid-operation aborts immediately. No result is emitted. The block restarts in IDLE.
- States: IDLE, COMPUTE, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at edge k; cipher, d and n are registered at that edge.
  - If n < 2 or cipher >= n: go to DONE with error=1, message=0. out_valid is visible after edge k.
  - Otherwise: result=1, base=cipher, exp=d, bit counter=0, step counter=0; go to COMPUTE.
- COMPUTE: WIDTH exponent-bit periods of WIDTH cycles each, exactly WIDTH*WIDTH cycles (256 for WIDTH=16). Count is independent of d's value.
  - Per period, two multipliers run in parallel on base bits, MSB-first, with base held constant:
    - P1 = result*base mod n
    - P2 = base*base mod n
  - Interleaved step per cycle, for each accumulator acc (WIDTH+1 bits) with addend a < n:
    - t = 2*acc; if t >= n then t -= n
    - if the current base bit is set: t += a; if t >= n then t -= n
    - acc <= t
  - Accumulators are cleared at the start of each period. Intermediates never exceed 2n-1, so WIDTH+1 bits is sufficient.
  - At the end of each period:
    - result <= exp[0] ? P1 : result (P1 is always computed, for constant time)
    - base <= P2
    - exp <= exp >> 1
  - After the last period, go to DONE with message=result, error=0. out_valid is visible after edge k+WIDTH*WIDTH.
- DONE: out_valid=1. message and error are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE. out_valid=0 and in_ready=1 on the next cycle. message and error keep their last values.
- in_valid is ignored outside IDLE. No operand is queued.
- Boundary cases:
  - d=0 gives message=1.
  - cipher=0 with d>0 gives 0.
  - n=2^WIDTH-1 must not overflow.
  - in_valid and out_ready are independent. A new operand can be accepted only the cycle after the result handshake.

Test Plan:
- n=3233, d=2753, cipher=2790 -> out_valid exactly 256 cycles after accept; message=65, error=0.
- Round trip: encrypt m=1234 with e=17, n=3233 on the team's encryption core, then feed the ciphertext here with d=2753 -> message=1234. Sweep 50 random m < 3233 and compare against a software modexp reference.
- n=65535, d=2, cipher=65534 -> message=1 (checks the WIDTH+1-bit accumulator). Also n=65535, d=0, cipher=7 -> message=1.
- Rejections:
  - n=1, cipher=0 -> out_valid the cycle after accept, error=1, message=0.
  - n=3233, cipher=3233 -> error=1.
  - After each rejection, a valid job completes normally.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid, message and error stable; in_ready=0. Pulsing in_valid during COMPUTE/DONE does not start a new job.
- Drop reset_n mid-COMPUTE (cycle 100) -> outputs reach their reset values immediately. A fresh job (cipher=2790, d=2753, n=3233) then returns 65 with full 256-cycle latency.
